mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl -- multiply/divide unit controller with architectural HI/LO.
//
// An accepted mult/multu/div/divu computes its result at the accept edge,
// parks it in shadow registers, counts down a fixed latency and then commits
// it to HI/LO.
// Latency is 5 cycles for the multiply class and 10 cycles for the divide
// class. mthi/mtlo write HI/LO at the accept edge and never raise busy.
//
// Optional feature: define MDU_MADD_EN to enable madd/maddu (ops 7 and 8).
// These accumulate the product into {hi,lo}. Without the macro both opcodes
// decode as "none".
//
// Ports:
//   clk      in   1  sole clock, rising edge
//   reset    in   1  synchronous active-high reset (beats start)
//   start    in   1  E-stage MDU instruction valid
//   mdu_op   in   4  0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,
//                    7 madd,8 maddu; all other values are treated as none
//   in1      in  32  rs operand
//   in2      in  32  rt operand
//   inhibit  in   1  flush: suppresses this cycle's start
//   busy     out  1  operation in progress
//   hi       out 32  architectural HI
//   lo       out 32  architectural LO
// ---------------------------------------------------------------------------
module mdu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        inhibit,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    localparam logic [3:0] MUL_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT = 4'd10;

    logic [0:0]  state_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] res_hi_reg;
    logic [31:0] res_lo_reg;
    logic        res_wr_reg;   // low for divide-by-zero: HI/LO left untouched

    // ---------------- opcode decode ----------------
    logic mul_op;
    logic mul_signed;
    logic mul_acc;
    logic div_op;
    logic div_signed;
    logic mthi_op;
    logic mtlo_op;

    always_comb begin
        mul_op     = 1'b0;
        mul_signed = 1'b0;
        mul_acc    = 1'b0;
        div_op     = 1'b0;
        div_signed = 1'b0;
        mthi_op    = 1'b0;
        mtlo_op    = 1'b0;
        case (mdu_op)
            OP_MULT:  begin mul_op = 1'b1; mul_signed = 1'b1; end
            OP_MULTU: begin mul_op = 1'b1; end
            OP_DIV:   begin div_op = 1'b1; div_signed = 1'b1; end
            OP_DIVU:  begin div_op = 1'b1; end
            OP_MTHI:  begin mthi_op = 1'b1; end
            OP_MTLO:  begin mtlo_op = 1'b1; end
`ifdef MDU_MADD_EN
            OP_MADD:  begin mul_op = 1'b1; mul_signed = 1'b1; mul_acc = 1'b1; end
            OP_MADDU: begin mul_op = 1'b1; mul_acc = 1'b1; end
`endif
            default:  ;
        endcase
    end

    logic accept;
    assign accept = start && !inhibit && (state_reg == ST_IDLE);

    // ---------------- multiplier ----------------
    // Operands are sign- or zero-extended to 64 bits. The low 64 bits of the
    // 64x64 product are then the correct signed or unsigned 32x32 result.
    logic [63:0] mul_a_ext;
    logic [63:0] mul_b_ext;
    logic [63:0] product;
    logic [63:0] mul_result;

    assign mul_a_ext[31:0] = in1;
    assign mul_b_ext[31:0] = in2;

    generate
        for (genvar gi = 32; gi < 64; gi++) begin : g_ext
            assign mul_a_ext[gi] = mul_signed & in1[31];
            assign mul_b_ext[gi] = mul_signed & in2[31];
        end
    endgenerate

    assign product    = mul_a_ext * mul_b_ext;
    assign mul_result = mul_acc ? ({hi_reg, lo_reg} + product) : product;

    // ---------------- divider ----------------
    // Signed division is done on magnitudes and the signs are fixed up
    // afterwards. The magnitude of 0x80000000 is 0x80000000 as an unsigned
    // value, so 0x80000000 / -1 naturally yields quotient 0x80000000 and
    // remainder 0.
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_den;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign neg_a   = div_signed & in1[31];
    assign neg_b   = div_signed & in2[31];
    assign mag_a   = neg_a ? (32'd0 - in1) : in1;
    assign mag_b   = neg_b ? (32'd0 - in2) : in2;
    // The divisor is kept non-zero so the operator stays defined. A zero
    // divisor result is discarded through res_wr_reg anyway.
    assign div_den = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag   = mag_a / div_den;
    assign r_mag   = mag_a % div_den;
    assign quot    = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    assign rem     = neg_a ? (32'd0 - r_mag) : r_mag;

    // ---------------- control and state ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 4'd0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
            res_hi_reg <= 32'd0;
            res_lo_reg <= 32'd0;
            res_wr_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (mthi_op) hi_reg <= in1;
                        if (mtlo_op) lo_reg <= in1;
                        if (mul_op) begin
                            res_hi_reg <= mul_result[63:32];
                            res_lo_reg <= mul_result[31:0];
                            res_wr_reg <= 1'b1;
                            cnt_reg    <= MUL_LAT;
                            state_reg  <= ST_BUSY;
                        end
                        if (div_op) begin
                            res_hi_reg <= rem;
                            res_lo_reg <= quot;
                            res_wr_reg <= (in2 != 32'd0);
                            cnt_reg    <= DIV_LAT;
                            state_reg  <= ST_BUSY;
                        end
                    end
                end
                default: begin
                    // In BUSY, inhibit and start are ignored. The operation
                    // always runs to completion.
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        if (res_wr_reg) begin
                            hi_reg <= res_hi_reg;
                            lo_reg <= res_lo_reg;
                        end
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state_reg == ST_BUSY);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule
